// File: rtl/mag_calc_pkg.sv
// Shared constants and helpers for the polar-to-rectangular CORDIC converter.
package mag_calc_pkg;

  localparam logic [15:0] KCONST = 16'd39797;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ROT  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  // atan(2^-i) in 16-bit turn units (65536 = 360 deg)
  function automatic logic [15:0] atan_entry(input logic [3:0] i);
    case (i)
      4'd0:    return 16'd8192;
      4'd1:    return 16'd4836;
      4'd2:    return 16'd2555;
      4'd3:    return 16'd1297;
      4'd4:    return 16'd651;
      4'd5:    return 16'd326;
      4'd6:    return 16'd163;
      4'd7:    return 16'd81;
      4'd8:    return 16'd41;
      4'd9:    return 16'd20;
      4'd10:   return 16'd10;
      4'd11:   return 16'd5;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic signed [8:0] sat9(input logic signed [31:0] v);
    if (v > 32'sd255)       return 9'sd255;
    else if (v < -32'sd255) return -9'sd255;
    else                    return v[8:0];
  endfunction

endpackage

// File: rtl/mag_polar_to_rect_if.sv
// Request/result handshake bundle for mag_polar_to_rect.
interface mag_polar_to_rect_if;
  logic              start;
  logic [7:0]        mag;
  logic [7:0]        angle;
  logic              ready;
  logic              done;
  logic signed [8:0] x_out;
  logic signed [8:0] y_out;

  modport master (output start, mag, angle, input ready, done, x_out, y_out);
  modport slave  (input start, mag, angle, output ready, done, x_out, y_out);
endinterface

// File: rtl/cordic_stage.sv
// One combinational rotation-mode CORDIC micro-rotation, shared across iterations.
module cordic_stage
  import mag_calc_pkg::*;
#(
  parameter int DW = 20,
  parameter int AW = 16
) (
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] y,
  input  logic signed [AW-1:0] z,
  input  logic [3:0]           i,
  output logic signed [DW-1:0] x_next,
  output logic signed [DW-1:0] y_next,
  output logic signed [AW-1:0] z_next
);

  logic signed [DW-1:0] xs;
  logic signed [DW-1:0] ys;
  logic signed [AW-1:0] a;

  assign xs = x >>> i;
  assign ys = y >>> i;
  assign a  = $signed(AW'(atan_entry(i)));

  always_comb begin
    x_next = x;
    y_next = y;
    z_next = z;
    if (!z[AW-1]) begin
      x_next = x - ys;
      y_next = y + xs;
      z_next = z - a;
    end else begin
      x_next = x + ys;
      y_next = y - xs;
      z_next = z + a;
    end
  end

endmodule

// File: rtl/mag_polar_to_rect.sv
// Iterative CORDIC converting (magnitude, angle) to rounded, saturated signed (x, y).
module mag_polar_to_rect #(
  parameter int N_ITER = 12,
  parameter int FRAC   = 8,
  parameter int DW     = 20,
  parameter int AW     = 16
) (
  input  logic               clk,
  input  logic               rst,
  mag_polar_to_rect_if.slave bus
);
  import mag_calc_pkg::*;

  localparam logic signed [DW-1:0] HALF = DW'(2**(FRAC-1));

  logic [1:0]           state;
  logic [3:0]           iter;
  logic signed [DW-1:0] x, y, x_nx, y_nx;
  logic signed [AW-1:0] z, z_nx;
  logic                 done_q;
  logic signed [8:0]    x_q, y_q;

  logic [23:0]          prod;
  logic signed [DW-1:0] x_mag, x_load;
  logic [AW-1:0]        z_raw;
  logic signed [AW-1:0] z_load;
  logic                 fold;
  logic signed [DW-1:0] xr, yr;

  assign prod   = 24'(bus.mag) * 24'(KCONST);
  assign x_mag  = DW'(prod >> (16 - FRAC));
  assign fold   = bus.angle[7] ^ bus.angle[6];
  assign z_raw  = {bus.angle, {(AW-8){1'b0}}};
  assign x_load = fold ? -x_mag : x_mag;
  // Subtracting half a turn modulo 2^AW is just an MSB flip.
  assign z_load = fold ? $signed({~z_raw[AW-1], z_raw[AW-2:0]}) : $signed(z_raw);

  assign xr = (x + HALF) >>> FRAC;
  assign yr = (y + HALF) >>> FRAC;

  cordic_stage #(.DW(DW), .AW(AW)) u_stage (
    .x      (x),
    .y      (y),
    .z      (z),
    .i      (iter),
    .x_next (x_nx),
    .y_next (y_nx),
    .z_next (z_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      iter   <= '0;
      x      <= '0;
      y      <= '0;
      z      <= '0;
      done_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x     <= x_load;
            y     <= '0;
            z     <= z_load;
            iter  <= '0;
            state <= ROT;
          end
        end
        ROT: begin
          x <= x_nx;
          y <= y_nx;
          z <= z_nx;
          if (iter == 4'(N_ITER - 1)) state <= OUT;
          else                        iter  <= iter + 4'd1;
        end
        OUT: begin
          x_q    <= sat9(32'(xr));
          y_q    <= sat9(32'(yr));
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = done_q;
  assign bus.x_out = x_q;
  assign bus.y_out = y_q;

endmodule

// File: tb/tb_mag_polar_to_rect.sv
// Randomized self-checking bench for mag_polar_to_rect against a floating-point trig model.
module tb_mag_polar_to_rect;

  localparam real PI = 3.14159265358979323846;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mag_polar_to_rect_if bus ();

  mag_polar_to_rect #(.N_ITER(12), .FRAC(8), .DW(20), .AW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp, input int tol);
    n_tests++;
    if (got - exp > tol || exp - got > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int ideal(input int m, input int a, input bit sine);
    real ang, v;
    ang = 2.0 * PI * a / 256.0;
    v   = m * (sine ? $sin(ang) : $cos(ang));
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  // glitch=1 pulses a second start 4 cycles into the computation.
  task automatic run_op(input logic [7:0] m, input logic [7:0] a, input bit glitch, input string tag);
    int ex, ey, px, py, n, rlow, moved;
    bit got;
    ex = ideal(m, a, 1'b0);
    ey = ideal(m, a, 1'b1);
    px = bus.x_out;
    py = bus.y_out;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mag   = m;
    bus.angle = a;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mag   = 8'($urandom);
    bus.angle = 8'($urandom);
    n = 0; rlow = 0; moved = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (glitch && n == 4) begin
        bus.start = 1'b1;
        bus.mag   = 8'(m + 8'd50);
        bus.angle = 8'(a + 8'd100);
      end else if (glitch && n == 5) begin
        bus.start = 1'b0;
      end
      if (n <= 12 && !bus.ready) rlow++;
      if (bus.done) got = 1'b1;
      else if (int'(bus.x_out) != px || int'(bus.y_out) != py) moved++;
    end
    check({tag, "_latency"}, n, 13, 0);
    check({tag, "_busy"}, rlow, 12, 0);
    check({tag, "_hold"}, moved, 0, 0);
    check({tag, "_ready_at_done"}, int'(bus.ready), 1, 0);
    check({tag, "_x"}, int'(bus.x_out), ex, 1);
    check({tag, "_y"}, int'(bus.y_out), ey, 1);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, int'(bus.done), 0, 0);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) cnt++;
    end
  endtask

  initial begin
    int cnt;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.mag   = '0;
    bus.angle = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", int'(bus.ready), 1, 0);
    check("rst_done", int'(bus.done), 0, 0);
    check("rst_x", int'(bus.x_out), 0, 0);
    check("rst_y", int'(bus.y_out), 0, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(8'd10, 8'd0, 1'b0, "a0");
    run_op(8'd10, 8'd64, 1'b0, "a64");
    run_op(8'd10, 8'd128, 1'b0, "a128");
    run_op(8'd10, 8'd192, 1'b0, "a192");
    run_op(8'd255, 8'd32, 1'b0, "m255_a32");
    run_op(8'd255, 8'd160, 1'b0, "m255_a160");
    run_op(8'd10, 8'd38, 1'b0, "round_trip");
    run_op(8'd0, 8'($urandom), 1'b0, "mag0");

    run_op(8'd200, 8'd20, 1'b1, "ignored_start");
    count_dones(20, cnt);
    check("ignored_start_extra_done", cnt, 0, 0);

    run_op(8'd100, 8'd40, 1'b0, "pre_rst");
    @(negedge clk);
    bus.start = 1'b1;
    bus.mag   = 8'd77;
    bus.angle = 8'd10;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    count_dones(6, cnt);
    check("midrst_early_done", cnt, 0, 0);
    rst = 1'b1;
    #1;
    check("midrst_ready", int'(bus.ready), 1, 0);
    check("midrst_x", int'(bus.x_out), 0, 0);
    check("midrst_y", int'(bus.y_out), 0, 0);
    check("midrst_done", int'(bus.done), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    count_dones(20, cnt);
    check("midrst_lost", cnt, 0, 0);
    run_op(8'd77, 8'd10, 1'b0, "post_rst");

    for (int k = 0; k < 40; k++) begin
      run_op(8'($urandom), 8'($urandom), 1'b0, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
